// File: rtl/relu_backward.sv
// relu_backward: chunked ReLU gradient gate.
// The vector is processed LANES elements per clock. An element's upstream
// gradient passes unchanged where its forward input was strictly positive,
// otherwise it is zeroed. The pass also counts the active elements.
module relu_backward #(
    parameter int WIDTH      = 128,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [WIDTH*DATA_WIDTH-1:0]   fwd_input,
    input  logic [WIDTH*DATA_WIDTH-1:0]   grad_in,
    output logic [WIDTH*DATA_WIDTH-1:0]   grad_out,
    output logic [$clog2(WIDTH+1)-1:0]    active_count,
    output logic                          busy,
    output logic                          done
);

    localparam int NCHUNK     = WIDTH / LANES;
    localparam int CHUNK_BITS = LANES * DATA_WIDTH;
    localparam int CW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CNTW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                        state_r;
    logic [CW-1:0]                 chunk_r;
    logic [CNTW-1:0]               run_count_r;
    logic [WIDTH*DATA_WIDTH-1:0]   grad_out_r;
    logic [CNTW-1:0]               active_count_r;
    logic                          busy_r;
    logic                          done_r;

    int                            chunk_base_s;
    logic [CHUNK_BITS-1:0]         chunk_x_s;
    logic [CHUNK_BITS-1:0]         chunk_dy_s;
    logic [CHUNK_BITS-1:0]         chunk_dx_s;
    logic [CNTW-1:0]               lane_cnt_s;

    // Strictly positive in two's complement: sign bit clear and not zero.
    function automatic logic is_positive(input logic [DATA_WIDTH-1:0] v);
        return (v[DATA_WIDTH-1] == 1'b0) && (v != '0);
    endfunction

    // Gate each lane of the current chunk by its forward sign and count active lanes
    always_comb begin
        chunk_base_s = int'(chunk_r) * CHUNK_BITS;
        chunk_x_s    = fwd_input[chunk_base_s +: CHUNK_BITS];
        chunk_dy_s   = grad_in[chunk_base_s +: CHUNK_BITS];
        chunk_dx_s   = '0;
        lane_cnt_s   = '0;
        for (int l = 0; l < LANES; l++) begin
            if (is_positive(chunk_x_s[l*DATA_WIDTH +: DATA_WIDTH])) begin
                chunk_dx_s[l*DATA_WIDTH +: DATA_WIDTH] = chunk_dy_s[l*DATA_WIDTH +: DATA_WIDTH];
                lane_cnt_s = lane_cnt_s + CNTW'(1);
            end else begin
                chunk_dx_s[l*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end

    // Pass sequencer: IDLE -> RUN (one chunk per edge) -> DONE, with abort on enable drop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            chunk_r        <= '0;
            run_count_r    <= '0;
            grad_out_r     <= '0;
            active_count_r <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        state_r     <= ST_RUN;
                        chunk_r     <= '0;
                        run_count_r <= '0;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                    end else begin
                        busy_r      <= 1'b0;
                        done_r      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        // Abort: chunks already written stay, count is not published.
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else begin
                        grad_out_r[chunk_base_s +: CHUNK_BITS] <= chunk_dx_s;
                        if (chunk_r == LAST_CHUNK) begin
                            state_r        <= ST_DONE;
                            active_count_r <= run_count_r + lane_cnt_s;
                            busy_r         <= 1'b0;
                            done_r         <= 1'b1;
                        end else begin
                            chunk_r     <= chunk_r + CW'(1);
                            run_count_r <= run_count_r + lane_cnt_s;
                        end
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                    end else begin
                        done_r  <= 1'b1;
                    end
                    busy_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign grad_out     = grad_out_r;
    assign active_count = active_count_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_relu_backward.sv
// Scoreboard bench for relu_backward: expected completions are queued by the
// stimulus thread and checked by a monitor whenever done rises.
module tb_relu_backward;

    localparam int W    = 128;
    localparam int D    = 16;
    localparam int L    = 8;
    localparam int VB   = W * D;
    localparam int CNTW = $clog2(W + 1);

    typedef struct packed {
        logic [VB-1:0]   vec;
        logic [CNTW-1:0] cnt;
    } exp_t;

    logic            clk;
    logic            reset;
    logic            enable;
    logic [VB-1:0]   fwd_input;
    logic [VB-1:0]   grad_in;
    logic [VB-1:0]   grad_out;
    logic [CNTW-1:0] active_count;
    logic            busy;
    logic            done;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [VB-1:0] exp_v;
    logic [VB-1:0] held_v;

    relu_backward #(.WIDTH(W), .DATA_WIDTH(D), .LANES(L)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fwd_input    (fwd_input),
        .grad_in      (grad_in),
        .grad_out     (grad_out),
        .active_count (active_count),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_vec(input string nm, input logic [VB-1:0] act, input logic [VB-1:0] exp);
        n_cmp++;
        for (int i = 0; i < W; i++) begin
            if (act[i*D +: D] !== exp[i*D +: D]) begin
                n_bad++;
                $display("FAIL %s elem %0d got %h want %h", nm, i, act[i*D +: D], exp[i*D +: D]);
                break;
            end
        end
    endtask

    // Raise enable, wait for done within a bound, check 16-edge latency and busy.
    task automatic run_pass(input string nm);
        int cyc;
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        check_val({nm, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 40);
        check_val({nm, "_latency"}, cyc, 32'd16);
    endtask

    task automatic drop_enable(input string nm);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check_val({nm, "_done_low_after_drop"}, {31'd0, done}, 32'd0);
    endtask

    // Monitor: pop and compare one expected completion on each rising done.
    initial begin : monitor
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy && done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL busy_done_overlap got busy=%b done=%b want not both", busy, done);
            end
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done got done=1 want no completion");
                end else begin
                    e = exp_q.pop_front();
                    check_vec("sb_grad_out", grad_out, e.vec);
                    check_val("sb_active_count", 32'(active_count), 32'(e.cnt));
                end
            end
            done_prev = done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset     = 1'b0;
        enable    = 1'b0;
        fwd_input = '0;
        grad_in   = '0;
        #3;
        check_vec("reset_grad_out", grad_out, '0);
        check_val("reset_flags", {28'd0, active_count == '0, busy, done, 1'b0}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b1;

        // Alternating pattern with the zero, negative and positive specials at 0..2.
        for (int i = 0; i < W; i++) begin
            fwd_input[i*D +: D] = (i % 2 == 0) ? 16'h0200 : 16'hFE00;
            grad_in[i*D +: D]   = 16'h0100;
            exp_v[i*D +: D]     = (i % 2 == 0) ? 16'h0100 : 16'h0000;
        end
        fwd_input[0*D +: D] = 16'h0000;
        fwd_input[1*D +: D] = 16'hF000;
        fwd_input[2*D +: D] = 16'h1000;
        exp_v[0*D +: D]     = 16'h0000;
        exp_q.push_back('{vec: exp_v, cnt: 8'd63});
        run_pass("alt");
        drop_enable("alt");

        // Extremes: max positive x passes the most negative gradient untouched.
        for (int i = 0; i < W; i++) begin
            fwd_input[i*D +: D] = 16'h7FFF;
            grad_in[i*D +: D]   = 16'h8000;
            exp_v[i*D +: D]     = 16'h8000;
        end
        exp_q.push_back('{vec: exp_v, cnt: 8'd128});
        run_pass("ext_pos");
        drop_enable("ext_pos");

        // Abort after 5 RUN edges: chunks 0-4 rewritten, rest keep 16'h8000.
        for (int i = 0; i < W; i++) begin
            fwd_input[i*D +: D] = 16'h7FFF;
            grad_in[i*D +: D]   = 16'h1234;
            exp_v[i*D +: D]     = (i < 5 * L) ? 16'h1234 : 16'h8000;
        end
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_val("abort_no_done_in_run", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check_val("abort_busy_low", {31'd0, busy}, 32'd0);
        check_val("abort_done_low", {31'd0, done}, 32'd0);
        check_vec("abort_grad_out", grad_out, exp_v);
        check_val("abort_count_kept", 32'(active_count), 32'd128);

        // Asynchronous reset between edges during RUN.
        for (int i = 0; i < W; i++) begin
            fwd_input[i*D +: D] = (i < 64) ? 16'h0300 : 16'h0000;
            grad_in[i*D +: D]   = 16'h0100 + 16'(i);
            exp_v[i*D +: D]     = (i < 64) ? (16'h0100 + 16'(i)) : 16'h0000;
        end
        @(negedge clk);
        enable = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        check_vec("async_reset_grad_out", grad_out, '0);
        check_val("async_reset_busy", {31'd0, busy}, 32'd0);
        check_val("async_reset_done", {31'd0, done}, 32'd0);
        check_val("async_reset_count", 32'(active_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_val("post_reset_stays_idle", {31'd0, busy}, 32'd0);
        exp_q.push_back('{vec: exp_v, cnt: 8'd64});
        run_pass("after_reset");

        // Hold enable 10 cycles past done; changed inputs must not disturb outputs.
        held_v = exp_v;
        for (int i = 0; i < W; i++) begin
            fwd_input[i*D +: D] = 16'h8000;
            grad_in[i*D +: D]   = 16'h8000;
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check_val("hold_done_high", {31'd0, done}, 32'd1);
            check_vec("hold_grad_out", grad_out, held_v);
            check_val("hold_count", 32'(active_count), 32'd64);
        end
        drop_enable("hold");
        @(posedge clk);
        #1;
        check_vec("idle_grad_out_held", grad_out, held_v);

        // Re-raised enable: all-negative x clears every gradient, count 0.
        exp_v = '0;
        exp_q.push_back('{vec: exp_v, cnt: 8'd0});
        run_pass("ext_neg");
        drop_enable("ext_neg");

        repeat (3) @(negedge clk);
        check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
